// File: rtl/alu_ctrl_pkg.sv
// Shared ALU operation codes, alu_op classes and FSM state type for the
// registered ALU control unit.
package alu_ctrl_pkg;

    localparam logic [4:0] ALU_SUB    = 5'h00;
    localparam logic [4:0] ALU_ADD    = 5'h01;
    localparam logic [4:0] ALU_AND    = 5'h02;
    localparam logic [4:0] ALU_OR     = 5'h03;
    localparam logic [4:0] ALU_XOR    = 5'h04;
    localparam logic [4:0] ALU_SLL    = 5'h05;
    localparam logic [4:0] ALU_SRL    = 5'h06;
    localparam logic [4:0] ALU_SRA    = 5'h07;
    localparam logic [4:0] ALU_SLT    = 5'h08;
    localparam logic [4:0] ALU_SLTU   = 5'h09;
    localparam logic [4:0] ALU_PASS_B = 5'h0A;
    localparam logic [4:0] ALU_MBASE  = 5'h10;
    localparam logic [4:0] ALU_NOP    = 5'h1F;

    localparam logic [2:0] OP_LDST   = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_RTYPE  = 3'b010;
    localparam logic [2:0] OP_ITYPE  = 3'b011;
    localparam logic [2:0] OP_JAL    = 3'b100;
    localparam logic [2:0] OP_LUI    = 3'b101;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VALID,
        ST_BUSY
    } state_t;

    // funct3 meaning shared by R-type (funct7=0) and I-type ops
    function automatic logic [4:0] base_op(input logic [2:0] f3);
        logic [4:0] code;
        case (f3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational decode of alu_op/funct3/funct7 into an ALU code plus
// immediate, illegal and multicycle classification.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int MULDIV_EN = 1
) (
    input  logic [2:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [4:0] code,
    output logic       is_imm,
    output logic       illegal,
    output logic       multicycle,
    output logic       is_div
);

    always_comb begin
        code       = ALU_NOP;
        is_imm     = 1'b0;
        illegal    = 1'b0;
        multicycle = 1'b0;
        is_div     = 1'b0;
        case (alu_op)
            OP_LDST: begin
                code   = ALU_ADD;
                is_imm = 1'b1;
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: code = ALU_SUB;
                    3'b100, 3'b101: code = ALU_SLT;
                    3'b110, 3'b111: code = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            OP_RTYPE: begin
                if (funct7 == F7_BASE) begin
                    code = base_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    code = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    code = ALU_SRA;
                end else if (MULDIV_EN != 0 && funct7 == F7_MULDIV) begin
                    code       = ALU_MBASE | {2'b00, funct3};
                    multicycle = 1'b1;
                    is_div     = funct3[2];
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ITYPE: begin
                // Only the shift immediates carry meaning in funct7
                is_imm = 1'b1;
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    illegal = 1'b1;
                end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
                    code = ALU_SRA;
                end else if (funct3 == 3'b101 && funct7 != F7_BASE) begin
                    illegal = 1'b1;
                end else begin
                    code = base_op(funct3);
                end
            end
            OP_JAL: code = ALU_ADD;
            OP_LUI: begin
                code   = ALU_PASS_B;
                is_imm = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            code   = ALU_NOP;
            is_imm = 1'b0;
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control: holds one decoded result for the
// consumer and sequences the busy window of multicycle MUL/DIV ops.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W    = 5,
    parameter int MULDIV_EN = 1,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 33
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    output logic              ctrl_valid,
    input  logic              ctrl_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              is_imm,
    output logic              illegal,
    output logic              alu_busy,
    output logic              mc_done
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       code_q;
    logic             imm_q, ill_q, mc_q, div_q;
    logic [4:0]       dec_code;
    logic             dec_imm, dec_ill, dec_mc, dec_div;
    logic             accept;

    alu_ctrl_decode #(
        .MULDIV_EN (MULDIV_EN)
    ) u_decode (
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7     (funct7),
        .code       (dec_code),
        .is_imm     (dec_imm),
        .illegal    (dec_ill),
        .multicycle (dec_mc),
        .is_div     (dec_div)
    );

    // A held multicycle op must hand off to BUSY before anything new enters
    always_comb begin
        req_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE:  req_ready = 1'b1;
                ST_VALID: req_ready = ctrl_ready && !mc_q;
                default:  req_ready = 1'b0;
            endcase
        end
    end

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_VALID;
            end
            ST_VALID: begin
                if (ctrl_ready) begin
                    if (mc_q) begin
                        state_d = ST_BUSY;
                        cnt_d   = div_q ? DIV_LOAD : MUL_LOAD;
                    end else if (!accept) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            code_q  <= ALU_NOP;
            imm_q   <= 1'b0;
            ill_q   <= 1'b0;
            mc_q    <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                code_q <= dec_code;
                imm_q  <= dec_imm;
                ill_q  <= dec_ill;
                mc_q   <= dec_mc;
                div_q  <= dec_div;
            end
        end
    end

    assign ctrl_valid = (state_q == ST_VALID);
    assign alu_busy   = (state_q == ST_BUSY);
    assign mc_done    = alu_busy && (cnt_q == '0);
    assign alu_ctrl   = CTRL_W'(code_q);
    assign is_imm     = imm_q;
    assign illegal    = ill_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_alu_ctrl_seq;
    import alu_ctrl_pkg::*;

    localparam int TB_MUL_LAT = 12;
    localparam int TB_DIV_LAT = 33;
    localparam logic [9:0] RST_OUTS = {1'b0, 5'h1F, 4'b0000};

    localparam logic [4:0] RTAB [8] = '{5'h01, 5'h05, 5'h08, 5'h09, 5'h04, 5'h06, 5'h03, 5'h02};
    localparam logic [4:0] BTAB [4] = '{5'h00, 5'h1F, 5'h08, 5'h09};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       ctrl_ready = 1'b0;
    logic [2:0] alu_op = 3'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;

    logic       req_ready, ctrl_valid, is_imm, illegal, alu_busy, mc_done;
    logic [4:0] alu_ctrl;
    logic       n_req_ready, n_ctrl_valid, n_is_imm, n_illegal, n_alu_busy, n_mc_done;
    logic [4:0] n_alu_ctrl;
    logic       q_req_ready, q_ctrl_valid, q_is_imm, q_illegal, q_alu_busy, q_mc_done;
    logic [7:0] q_alu_ctrl;
    logic [9:0] outs;

    int checks = 0;
    int errors = 0;

    assign outs = {ctrl_valid, alu_ctrl, is_imm, illegal, alu_busy, mc_done};

    always #5 clk = ~clk;

    alu_ctrl_seq #(.CTRL_W(5), .MULDIV_EN(1), .MUL_LAT(TB_MUL_LAT), .DIV_LAT(TB_DIV_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .alu_ctrl(alu_ctrl),
        .is_imm(is_imm), .illegal(illegal), .alu_busy(alu_busy), .mc_done(mc_done)
    );

    alu_ctrl_seq #(.CTRL_W(5), .MULDIV_EN(0), .MUL_LAT(4), .DIV_LAT(33)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(n_req_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
        .ctrl_valid(n_ctrl_valid), .ctrl_ready(ctrl_ready), .alu_ctrl(n_alu_ctrl),
        .is_imm(n_is_imm), .illegal(n_illegal), .alu_busy(n_alu_busy), .mc_done(n_mc_done)
    );

    alu_ctrl_seq #(.CTRL_W(8), .MULDIV_EN(1), .MUL_LAT(1), .DIV_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(q_req_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7),
        .ctrl_valid(q_ctrl_valid), .ctrl_ready(ctrl_ready), .alu_ctrl(q_alu_ctrl),
        .is_imm(q_is_imm), .illegal(q_illegal), .alu_busy(q_alu_busy), .mc_done(q_mc_done)
    );

    // Reference decode written directly from the encoding tables
    function automatic void ref_decode(input logic [2:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input bit md,
                                       output logic [4:0] code, output bit imm,
                                       output bit ill, output bit mc, output bit dv);
        code = 5'h1F; imm = 1'b0; ill = 1'b0; mc = 1'b0; dv = 1'b0;
        case (op)
            3'd0: begin code = 5'h01; imm = 1'b1; end
            3'd1: begin
                if (f3[2:1] == 2'b01) ill = 1'b1;
                else                  code = BTAB[f3[2:1]];
            end
            3'd2: begin
                if (f7 == 7'h00)                     code = RTAB[f3];
                else if (f7 == 7'h20 && f3 == 3'd0)  code = 5'h00;
                else if (f7 == 7'h20 && f3 == 3'd5)  code = 5'h07;
                else if (f7 == 7'h01 && md) begin
                    code = 5'h10 + {2'b00, f3};
                    mc   = 1'b1;
                    dv   = (f3 >= 3'd4);
                end else ill = 1'b1;
            end
            3'd3: begin
                imm = 1'b1;
                if (f3 == 3'd5 && f7 == 7'h20)                      code = 5'h07;
                else if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) ill = 1'b1;
                else                                                code = RTAB[f3];
            end
            3'd4: code = 5'h01;
            3'd5: begin code = 5'h0A; imm = 1'b1; end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            code = 5'h1F;
            imm  = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input bit v, input bit cr, input logic [2:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7);
        req_valid  = v;
        ctrl_ready = cr;
        alu_op     = op;
        funct3     = f3;
        funct7     = f7;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 7'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 7'd0);
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_req_ready got %b want 0", req_ready);
        end
        checks++;
        if (outs !== RST_OUTS) begin
            errors++; $display("[TB] FAIL reset_outputs got %b want %b", outs, RST_OUTS);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_release_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_sub();
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, OP_RTYPE, 3'b000, 7'b0100000);
        @(posedge clk); #1;
        checks++;
        if ({ctrl_valid, alu_ctrl, illegal, is_imm} !== {1'b1, 5'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sub_decode got v=%b c=%h ill=%b imm=%b want v=1 c=00 ill=0 imm=0",
                     ctrl_valid, alu_ctrl, illegal, is_imm);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0, 7'd0);
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        logic [2:0] f3s  [5] = '{3'b010, 3'b101, 3'b110, 3'b001, 3'b111};
        logic [6:0] f7s  [5] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
        logic [4:0] want [5] = '{5'h08, 5'h07, 5'h03, 5'h05, 5'h02};
        logic [6:0] f7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            // ORI/ANDI ignore funct7, so give them random junk
            f7 = (i == 2 || i == 4) ? 7'($urandom_range(0, 127)) : f7s[i];
            applyStimulus(1'b1, 1'b1, OP_ITYPE, f3s[i], f7);
            #1;
            checks++;
            if (req_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL b2b_ready[%0d] got %b want 1", i, req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if ({ctrl_valid, alu_ctrl, is_imm} !== {1'b1, want[i], 1'b1}) begin
                errors++;
                $display("[TB] FAIL b2b_result[%0d] got v=%b c=%h imm=%b want v=1 c=%h imm=1",
                         i, ctrl_valid, alu_ctrl, is_imm, want[i]);
            end
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0, 7'd0);
        @(posedge clk);
    endtask

    task automatic test_stall();
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, OP_BRANCH, 3'b110, 7'd0);
        @(posedge clk); #1;
        checks++;
        if ({ctrl_valid, alu_ctrl} !== {1'b1, 5'h09}) begin
            errors++; $display("[TB] FAIL stall_first got v=%b c=%h want v=1 c=09", ctrl_valid, alu_ctrl);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, OP_LDST, 3'd0, 7'd0);
            #1;
            checks++;
            if (req_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL stall_ready[%0d] got %b want 0", i, req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if ({ctrl_valid, alu_ctrl} !== {1'b1, 5'h09}) begin
                errors++; $display("[TB] FAIL stall_hold[%0d] got v=%b c=%h want v=1 c=09", i, ctrl_valid, alu_ctrl);
            end
        end
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, OP_LDST, 3'd0, 7'd0);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_release_ready got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({ctrl_valid, alu_ctrl, is_imm} !== {1'b1, 5'h01, 1'b1}) begin
            errors++; $display("[TB] FAIL stall_next got v=%b c=%h imm=%b want v=1 c=01 imm=1", ctrl_valid, alu_ctrl, is_imm);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0, 7'd0);
        @(posedge clk);
    endtask

    task automatic test_div();
        bit busy_a [50];
        bit done_a [50];
        bit rr_a   [50];
        bit cv_a   [50];
        logic [4:0] code_a [50];
        int first = -1, last = -1, busy_n = 0, bad = 0;
        applyReset();
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, OP_RTYPE, 3'b100, 7'b0000001);
        @(posedge clk); #1;
        checks++;
        if ({ctrl_valid, alu_ctrl, alu_busy} !== {1'b1, 5'h14, 1'b0}) begin
            errors++; $display("[TB] FAIL div_decode got v=%b c=%h busy=%b want v=1 c=14 busy=0", ctrl_valid, alu_ctrl, alu_busy);
        end
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, OP_LDST, 3'd0, 7'd0);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL div_held_ready got %b want 0", req_ready);
        end
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            busy_a[i] = alu_busy; done_a[i] = mc_done; cv_a[i] = ctrl_valid; code_a[i] = alu_ctrl;
            @(negedge clk); #1;
            rr_a[i] = req_ready;
        end
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0, 7'd0);
        for (int i = 0; i < 50; i++) begin
            if (busy_a[i]) begin
                busy_n++;
                if (first < 0) first = i;
                last = i;
            end
        end
        checks++;
        if (busy_n != TB_DIV_LAT || first < 0 || last - first + 1 != TB_DIV_LAT) begin
            errors++; $display("[TB] FAIL div_busy_len got %0d (span %0d..%0d) want %0d contiguous", busy_n, first, last, TB_DIV_LAT);
        end
        for (int i = 0; i < 50; i++) begin
            if (done_a[i] != (i == last)) bad++;
            if (busy_a[i] && rr_a[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("[TB] FAIL div_done_pulse got %0d bad cycles want 0", bad);
        end
        if (last >= 0 && last + 2 < 50) begin
            checks++;
            if ({rr_a[last+1], cv_a[last+1], cv_a[last+2], code_a[last+2]} !== {1'b1, 1'b0, 1'b1, 5'h01}) begin
                errors++;
                $display("[TB] FAIL div_after got rr=%b v=%b v2=%b c2=%h want rr=1 v=0 v2=1 c2=01",
                         rr_a[last+1], cv_a[last+1], cv_a[last+2], code_a[last+2]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0] ops [3] = '{3'b110, 3'b011, 3'b111};
        logic [2:0] f3s [3] = '{3'b000, 3'b101, 3'b010};
        logic [6:0] f7s [3] = '{7'h00, 7'b0000011, 7'h00};
        applyReset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b1, ops[i], f3s[i], f7s[i]);
            @(posedge clk); #1;
            checks++;
            if ({ctrl_valid, illegal, alu_ctrl, alu_busy} !== {1'b1, 1'b1, 5'h1F, 1'b0}) begin
                errors++;
                $display("[TB] FAIL illegal[%0d] got v=%b ill=%b c=%h busy=%b want v=1 ill=1 c=1f busy=0",
                         i, ctrl_valid, illegal, alu_ctrl, alu_busy);
            end
            @(negedge clk);
            applyStimulus(1'b0, 1'b1, 3'd0, 3'd0, 7'd0);
            @(posedge clk); #1;
            checks++;
            if ({ctrl_valid, alu_busy} !== 2'b00) begin
                errors++; $display("[TB] FAIL illegal_after[%0d] got v=%b busy=%b want 0 0", i, ctrl_valid, alu_busy);
            end
        end
        applyReset();
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, OP_RTYPE, 3'b000, 7'b0000001);
        @(posedge clk); #1;
        checks++;
        if ({n_ctrl_valid, n_illegal, n_alu_ctrl, n_is_imm, n_alu_busy} !== {1'b1, 1'b1, 5'h1F, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL nomuldiv got v=%b ill=%b c=%h imm=%b busy=%b want v=1 ill=1 c=1f imm=0 busy=0",
                     n_ctrl_valid, n_illegal, n_alu_ctrl, n_is_imm, n_alu_busy);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0, 7'd0);
        @(posedge clk); #1;
        checks++;
        if ({n_alu_busy, n_mc_done, n_ctrl_valid, n_req_ready} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL nomuldiv_after got busy=%b done=%b v=%b rr=%b want 0 0 0 1",
                     n_alu_busy, n_mc_done, n_ctrl_valid, n_req_ready);
        end
        applyReset();
    endtask

    task automatic test_lat1();
        applyReset();
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, OP_RTYPE, 3'b000, 7'b0000001);
        @(posedge clk); #1;
        checks++;
        if ({q_ctrl_valid, q_alu_ctrl, q_illegal, q_is_imm} !== {1'b1, 8'h10, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL lat1_decode got v=%b c=%h ill=%b imm=%b want v=1 c=10 0 0",
                               q_ctrl_valid, q_alu_ctrl, q_illegal, q_is_imm);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0, 7'd0);
        @(posedge clk); #1;
        checks++;
        if ({q_alu_busy, q_mc_done, q_ctrl_valid, q_req_ready} !== 4'b1100) begin
            errors++; $display("[TB] FAIL lat1_busy got busy=%b done=%b v=%b rr=%b want 1 1 0 0",
                               q_alu_busy, q_mc_done, q_ctrl_valid, q_req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({q_alu_busy, q_mc_done, q_req_ready} !== 3'b001) begin
            errors++; $display("[TB] FAIL lat1_end got busy=%b done=%b rr=%b want 0 0 1", q_alu_busy, q_mc_done, q_req_ready);
        end
        applyReset();
    endtask

    task automatic test_reset_busy();
        applyReset();
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, OP_RTYPE, 3'b001, 7'b0000001);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0, 7'd0);
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if ({alu_busy, alu_ctrl} !== {1'b1, 5'h11}) begin
            errors++; $display("[TB] FAIL rstbusy_pre got busy=%b c=%h want busy=1 c=11", alu_busy, alu_ctrl);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({outs, req_ready} !== {RST_OUTS, 1'b0}) begin
            errors++; $display("[TB] FAIL rstbusy_outputs got %b rr=%b want %b rr=0", outs, req_ready, RST_OUTS);
        end
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, OP_LDST, 3'd0, 7'd0);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL rstbusy_ready got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({ctrl_valid, alu_ctrl} !== {1'b1, 5'h01}) begin
            errors++; $display("[TB] FAIL rstbusy_accept got v=%b c=%h want v=1 c=01", ctrl_valid, alu_ctrl);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0, 7'd0);
        @(posedge clk);
    endtask

    // Transaction model: one held result, then an optional LAT-cycle busy window
    task automatic test_random();
        bit have = 1'b0, h_imm = 1'b0, h_ill = 1'b0, h_mc = 1'b0, h_dv = 1'b0;
        logic [4:0] h_code = 5'h1F;
        int busy_left = 0;
        bit exp_rr, acc, d_imm, d_ill, d_mc, d_dv;
        logic [4:0] d_code;
        logic [6:0] f7r;
        applyReset();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            case ($urandom % 4)
                0:       f7r = 7'h00;
                1:       f7r = 7'h20;
                2:       f7r = 7'h01;
                default: f7r = 7'($urandom % 128);
            endcase
            applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0, 3'($urandom % 8), 3'($urandom % 8), f7r);
            #1;
            exp_rr = (busy_left == 0) && (!have || (ctrl_ready && !h_mc));
            checks++;
            if (req_ready !== exp_rr) begin
                errors++; $display("[TB] FAIL rand_ready[%0d] got %b want %b", n, req_ready, exp_rr);
            end
            acc = req_valid && exp_rr;
            ref_decode(alu_op, funct3, funct7, 1'b1, d_code, d_imm, d_ill, d_mc, d_dv);
            @(posedge clk); #1;
            if (busy_left > 0) begin
                busy_left--;
            end else if (have && ctrl_ready) begin
                if (h_mc) busy_left = h_dv ? TB_DIV_LAT : TB_MUL_LAT;
                have = 1'b0;
            end
            if (acc) begin
                have = 1'b1; h_code = d_code; h_imm = d_imm; h_ill = d_ill; h_mc = d_mc; h_dv = d_dv;
            end
            checks++;
            if ({ctrl_valid, alu_busy, mc_done} !== {have, busy_left > 0, busy_left == 1}) begin
                errors++;
                $display("[TB] FAIL rand_state[%0d] got v=%b busy=%b done=%b want v=%b busy=%b done=%b",
                         n, ctrl_valid, alu_busy, mc_done, have, busy_left > 0, busy_left == 1);
            end
            if (have) begin
                checks++;
                if ({alu_ctrl, illegal} !== {h_code, h_ill}) begin
                    errors++; $display("[TB] FAIL rand_code[%0d] got c=%h ill=%b want c=%h ill=%b", n, alu_ctrl, illegal, h_code, h_ill);
                end
                if (!h_ill) begin
                    checks++;
                    if (is_imm !== h_imm) begin
                        errors++; $display("[TB] FAIL rand_imm[%0d] got %b want %b", n, is_imm, h_imm);
                    end
                end
            end
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 7'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_sub();
        test_back_to_back();
        test_stall();
        test_div();
        test_illegal();
        test_lat1();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
